// File: rtl/display_scan_if.sv
// Producer/display-side signal bundle for display_scan_ctrl.
// The master side is the data producer; the slave side is the scan controller.
interface display_scan_if #(
  parameter int unsigned NDIGITS = 2
);
  localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic                   enable;
  logic [3:0]             brightness;
  logic [4*NDIGITS-1:0]   bcd_in;
  logic [NDIGITS-1:0]     points_in;
  logic                   upd_req;
  logic                   upd_ack;
  logic [IW-1:0]          digit_idx;
  logic [3:0]             bcd_out;
  logic                   point_out;
  logic [NDIGITS-1:0]     catodes;
  logic                   frame_start;

  modport master (
    output enable, brightness, bcd_in, points_in, upd_req,
    input  upd_ack, digit_idx, bcd_out, point_out, catodes, frame_start
  );

  modport slave (
    input  enable, brightness, bcd_in, points_in, upd_req,
    output upd_ack, digit_idx, bcd_out, point_out, catodes, frame_start
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment refresh scheduler: per-digit PWM dwell, blanking gap
// between digits, and shadow data swapped only at frame boundaries.
module display_scan_ctrl #(
  parameter int unsigned NDIGITS     = 2,
  parameter int unsigned PRESCALE    = 1000,
  parameter int unsigned BLANK_TICKS = 1
) (
  input  logic           clk,
  input  logic           rst,
  display_scan_if.slave  bus
);
  localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned TW = ($clog2(BLANK_TICKS) > 4) ? $clog2(BLANK_TICKS) : 4;

  localparam logic [PW-1:0]      PRE_LAST   = PW'(PRESCALE - 1);
  localparam logic [TW-1:0]      ON_LAST    = TW'(15);
  localparam logic [TW-1:0]      BLANK_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [IW-1:0]      IDX_LAST   = IW'(NDIGITS - 1);
  localparam logic [NDIGITS-1:0] ONE_HOT0   = NDIGITS'(1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_BLANK} state_t;

  state_t               state, state_n;
  logic [PW-1:0]        pre, pre_n;
  logic [TW-1:0]        tick_cnt, tick_n;
  logic [IW-1:0]        idx, idx_n;
  logic [3:0]           br_q, br_n;
  logic [4*NDIGITS-1:0] sh_bcd, sh_bcd_n;
  logic [NDIGITS-1:0]   sh_pt, sh_pt_n;
  logic                 fs_n, ack_n, tick;
  logic [NDIGITS-1:0]   cat_n;
  logic [3:0]           bcd_sel;
  logic                 pt_sel;

  always_comb begin
    state_n  = state;
    pre_n    = '0;
    tick_n   = tick_cnt;
    idx_n    = idx;
    br_n     = br_q;
    sh_bcd_n = sh_bcd;
    sh_pt_n  = sh_pt;
    fs_n     = 1'b0;
    ack_n    = 1'b0;
    tick     = (pre == PRE_LAST);

    if (!bus.enable) begin
      state_n = S_IDLE;
      tick_n  = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state_n = S_ON;
          tick_n  = '0;
          idx_n   = '0;
          fs_n    = 1'b1;
        end
        S_ON: begin
          pre_n = tick ? '0 : pre + 1'b1;
          if (tick) begin
            if (tick_cnt == ON_LAST) begin
              state_n = S_BLANK;
              tick_n  = '0;
            end else begin
              tick_n = tick_cnt + 1'b1;
            end
          end
        end
        S_BLANK: begin
          pre_n = tick ? '0 : pre + 1'b1;
          if (tick) begin
            if (tick_cnt == BLANK_LAST) begin
              state_n = S_ON;
              tick_n  = '0;
              idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
              fs_n    = (idx == IDX_LAST);
            end else begin
              tick_n = tick_cnt + 1'b1;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    if (state_n == S_ON && state != S_ON) br_n = bus.brightness;

    if (fs_n && bus.upd_req) begin
      sh_bcd_n = bus.bcd_in;
      sh_pt_n  = bus.points_in;
      ack_n    = 1'b1;
    end

    // Outputs are registered from next-state values so they line up with catodes.
    bcd_sel = '0;
    pt_sel  = 1'b0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (idx_n == IW'(i)) begin
        bcd_sel = sh_bcd_n[4*i +: 4];
        pt_sel  = sh_pt_n[i];
      end
    end

    cat_n = '1;
    if (state_n == S_ON && tick_n < TW'(br_n)) cat_n = ~(ONE_HOT0 << idx_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      pre             <= '0;
      tick_cnt        <= '0;
      idx             <= '0;
      br_q            <= '0;
      sh_bcd          <= '0;
      sh_pt           <= '0;
      bus.catodes     <= '1;
      bus.bcd_out     <= '0;
      bus.point_out   <= 1'b0;
      bus.upd_ack     <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      state           <= state_n;
      pre             <= pre_n;
      tick_cnt        <= tick_n;
      idx             <= idx_n;
      br_q            <= br_n;
      sh_bcd          <= sh_bcd_n;
      sh_pt           <= sh_pt_n;
      bus.catodes     <= cat_n;
      bus.bcd_out     <= bcd_sel;
      bus.point_out   <= pt_sel;
      bus.upd_ack     <= ack_n;
      bus.frame_start <= fs_n;
    end
  end

  assign bus.digit_idx = idx;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a frame-position model that
// derives every output from the cycle offset since the current frame began.
module tb_display_scan_ctrl;
  localparam int unsigned NDIGITS = 2;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned BLANK_TICKS = 1;
  localparam int unsigned DIGP  = (16 + BLANK_TICKS) * PRESCALE;
  localparam int unsigned FRAME = NDIGITS * DIGP;

  logic clk = 1'b0;
  logic rst = 1'b1;

  display_scan_if #(.NDIGITS(NDIGITS)) bus ();

  display_scan_ctrl #(
    .NDIGITS(NDIGITS),
    .PRESCALE(PRESCALE),
    .BLANK_TICKS(BLANK_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_fs = -1;

  // reference model state
  bit                 m_active;
  int unsigned        m_t, m_br;
  logic [3:0]         m_bcd [NDIGITS];
  logic               m_pt  [NDIGITS];
  logic [NDIGITS-1:0] m_cat;
  int unsigned        m_idx, m_pos;
  logic [3:0]         m_bcdo;
  logic               m_pto, m_fs, m_ack;
  logic [NDIGITS-1:0] one_hot0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_t = 0; m_br = 0; m_pos = 0;
    for (int i = 0; i < NDIGITS; i++) begin m_bcd[i] = '0; m_pt[i] = 1'b0; end
    m_cat = '1; m_idx = 0; m_bcdo = '0; m_pto = 1'b0; m_fs = 1'b0; m_ack = 1'b0;
    last_fs = -1;
  endtask

  task automatic model_edge();
    int unsigned dig, off;
    cyc++;
    if (rst) begin model_reset(); return; end
    if (!bus.enable) begin
      m_active = 1'b0;
      m_cat = '1; m_idx = 0; m_fs = 1'b0; m_ack = 1'b0;
      m_bcdo = m_bcd[0]; m_pto = m_pt[0];
      last_fs = -1;
      return;
    end
    if (!m_active) begin m_active = 1'b1; m_t = 0; end
    else m_t++;
    m_pos = m_t % FRAME;
    dig = m_pos / DIGP;
    off = m_pos % DIGP;
    if (off == 0) m_br = bus.brightness;
    m_fs  = (m_pos == 0);
    m_ack = m_fs && bus.upd_req;
    if (m_ack) begin
      for (int i = 0; i < NDIGITS; i++) begin
        m_bcd[i] = bus.bcd_in[4*i +: 4];
        m_pt[i]  = bus.points_in[i];
      end
    end
    m_idx  = dig;
    m_bcdo = m_bcd[dig];
    m_pto  = m_pt[dig];
    m_cat  = (off < m_br * PRESCALE) ? ~(one_hot0 << dig) : '1;
  endtask

  task automatic compare_all();
    check("catodes",     32'(bus.catodes),     32'(m_cat));
    check("digit_idx",   32'(bus.digit_idx),   m_idx);
    check("bcd_out",     32'(bus.bcd_out),     32'(m_bcdo));
    check("point_out",   32'(bus.point_out),   32'(m_pto));
    check("frame_start", 32'(bus.frame_start), 32'(m_fs));
    check("upd_ack",     32'(bus.upd_ack),     32'(m_ack));
    if (!rst && bus.frame_start) begin
      if (last_fs >= 0) check("frame_period", 32'(cyc - last_fs), FRAME);
      last_fs = cyc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    one_hot0 = 1;
    bus.enable = 1'b0;
    bus.brightness = 4'd15;
    bus.bcd_in = '0;
    bus.points_in = '0;
    bus.upd_req = 1'b0;
    model_reset();

    // reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      bus.enable = 1'($urandom);
      bus.brightness = 4'($urandom);
      bus.bcd_in = 8'($urandom);
      bus.points_in = 2'($urandom);
      bus.upd_req = 1'($urandom);
      step();
    end

    // full brightness scan
    bus.enable = 1'b1; bus.brightness = 4'd15; bus.upd_req = 1'b0;
    #2 rst = 1'b0;
    for (int i = 0; i < 2 * FRAME + 10; i++) step();

    // async reset mid-ON, then restart
    async_reset();
    for (int i = 0; i < 30; i++) step();

    // zero brightness
    bus.brightness = 4'd0;
    for (int i = 0; i < 2 * FRAME; i++) step();

    // tear-free update requested 20 cycles into a frame
    bus.brightness = 4'd15;
    for (int i = 0; i < 2 * FRAME && !(m_active && m_pos == 20); i++) step();
    bus.bcd_in = 8'h37; bus.points_in = 2'b10; bus.upd_req = 1'b1;
    begin
      bit got_ack = 1'b0;
      for (int i = 0; i < FRAME + 10 && !got_ack; i++) begin
        step();
        got_ack = bus.upd_ack;
      end
      check("ack_timeout", 32'(got_ack), 32'd1);
    end
    bus.upd_req = 1'b0;
    bus.bcd_in = 8'h00;
    for (int i = 0; i < FRAME; i++) step();

    // brightness change mid-dwell of digit 0
    for (int i = 0; i < 2 * FRAME && !(m_active && m_pos == 10); i++) step();
    bus.brightness = 4'd4;
    for (int i = 0; i < FRAME; i++) step();

    // enable drop during digit 1 ON, then re-enable
    bus.brightness = 4'd15;
    for (int i = 0; i < 2 * FRAME && !(m_active && m_pos == DIGP + 25); i++) step();
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) step();
    bus.enable = 1'b1;
    for (int i = 0; i < FRAME + 20; i++) step();

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0) bus.brightness = 4'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        bus.upd_req = ~bus.upd_req;
        bus.bcd_in = 8'($urandom);
        bus.points_in = 2'($urandom);
      end
      if ($urandom_range(0, 299) == 0) bus.enable = 1'b0;
      else if ($urandom_range(0, 3) == 0) bus.enable = 1'b1;
      if ($urandom_range(0, 999) == 0) async_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Refresh scheduler for the multiplexed 7-segment display path. It steps through the digits, gating each digit's cathode for a programmable on-time and inserting a blanking gap between digits to prevent ghosting. It double-buffers the BCD/point data and swaps it only at frame boundaries, so a display never shows a torn frame. It sits between the data producer and the per-digit `to7seg` converters / cathode pins.

## Interface
- `NDIGITS`, 2: number of digits scanned; minimum 2.
- `PRESCALE`, 1000: `clk` cycles per scan tick; minimum 1.
- `BLANK_TICKS`, 1: ticks with all cathodes off between digits; minimum 1.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; asynchronous, active-high.
- `enable`  in  1  scan enable; low forces the display dark and idle.
- `brightness`  in  4  on-ticks per 16-tick digit dwell; 0 = dark, 15 = 15/16.
- `bcd_in`  in  4*NDIGITS  new data; digit i uses bits [4i+3:4i].
- `points_in`  in  NDIGITS  new decimal points; digit i uses bit i.
- `upd_req`  in  1  producer holds high until `upd_ack`.
- `upd_ack`  out  1  one-cycle pulse; shadow data captured.
- `digit_idx`  out  max(1,$clog2(NDIGITS))  index of the digit being scanned.
- `bcd_out`  out  4  shadow BCD of `digit_idx`, to the converter.
- `point_out`  out  1  shadow point of `digit_idx`.
- `catodes`  out  NDIGITS  active-low one-hot digit enable; all ones = dark.
- `frame_start`  out  1  one-cycle pulse at the start of digit 0's dwell.

## Operation
- Prescaler:
  - Counts 0..PRESCALE-1 while enabled.
  - A tick occurs in the cycle where the count is PRESCALE-1.
  - Held at 0 in IDLE.
- FSM states: IDLE, ON, BLANK.
  - IDLE: `catodes` all ones; `digit_idx` = 0; all counters 0. When `enable`=1, go to ON with idx 0 (frame start).
  - ON: `tick_cnt` runs 0..15.
    - `catodes` = ~(1<<idx) while tick_cnt < `br_q`, otherwise all ones.
    - On the tick where tick_cnt = 15, go to BLANK and clear tick_cnt.
  - BLANK: `catodes` all ones.
    - On the tick where tick_cnt = BLANK_TICKS-1, go to ON with idx+1.
    - idx wraps NDIGITS-1 to 0, and that wrap is a frame start.
  - `enable`=0 in any state: go to IDLE at the next edge. Shadow registers are retained.
- `br_q`: `brightness` is sampled on every entry to ON and held for that dwell. Mid-dwell changes have no effect.
- Frame start (entry to ON with idx 0, including from IDLE):
  - `frame_start` pulses.
  - If `upd_req`=1 at that edge, `bcd_in` and `points_in` are copied into the shadow registers, and `upd_ack` pulses in the same cycle as `frame_start`.
  - If `upd_req`=0, the shadow registers are unchanged and there is no ack.
- `upd_req` asserted or dropped mid-frame has no effect until the next frame start.
- `bcd_out` / `point_out`: registered selections from the shadow registers, indexed by the next `digit_idx`, so they align with `catodes`.

## Timing
- All outputs are registered.
- Reset values:
  - `catodes` all ones.
  - `digit_idx`, `bcd_out`, `point_out`, `upd_ack`, `frame_start` = 0.
  - Shadow registers, `br_q`, prescaler and tick_cnt = 0.
  - State = IDLE.
- `rst` asserted mid-frame: outputs take their reset values immediately (asynchronously).
- After `rst` deasserts with `enable`=1:
  - First frame start and first active cathode on the first rising edge following deassertion.
  - `frame_start` and `upd_ack` then pulse for that one cycle.
- Enable from IDLE: 1-cycle latency to ON.
- Disable: `catodes` all ones on the edge after `enable` falls.
- Digit period = (16+BLANK_TICKS)·PRESCALE cycles. Frame period = NDIGITS × digit period.
- On-time per digit = `br_q`·PRESCALE cycles, starting at the first cycle of ON.
- `upd_ack` latency after `upd_req` rises: 1 cycle to 1 frame period.

## Test plan
Parameters for all scenarios: NDIGITS=2, PRESCALE=4, BLANK_TICKS=1.

- **Reset:** hold `rst`=1 with random inputs → `catodes`=2'b11, `digit_idx`=0, `upd_ack`=0, `frame_start`=0. Assert `rst` mid-ON → same values without waiting for `clk`.
- **Full brightness scan:** `enable`=1, `brightness`=15 → `catodes`=2'b10 for 60 cycles, 2'b11 for 8, 2'b01 for 60, 2'b11 for 8. `frame_start` repeats every 136 cycles.
- **Zero brightness:** `brightness`=0 → `catodes` stays 2'b11; `digit_idx` still toggles every 68 cycles; `frame_start` every 136 cycles.
- **Tear-free update:**
  - Raise `upd_req` with `bcd_in`=8'h37, `points_in`=2'b10, 20 cycles into a frame.
  - `bcd_out` stays at the old values until the next frame start.
  - `upd_ack` pulses coincident with `frame_start`.
  - Then digit 0 shows `bcd_out`=4'h7, `point_out`=0; digit 1 shows 4'h3, `point_out`=1.
- **Brightness change mid-dwell:** change `brightness` 15→4 during digit 0 ON → digit 0 keeps 60 on-cycles; digit 1 gets 16 on-cycles.
- **Enable drop:** deassert `enable` during digit 1 ON → `catodes`=2'b11 on the next edge. Reassert → one cycle later `frame_start` pulses, `digit_idx`=0, and the shadow data is unchanged.
